filter_multi: RTL and testbench
===============================

Name: filter_multi

Overview:
- Multi-channel successor to the single-channel filter block.
- Processes NCHAN parallel signed sample streams, all sharing one enable/trig/mode.
- Per-channel result selected by mode: difference between triggers, window average, window minimum, or window maximum.
- Sits on the position bus like the single-channel filter and adds min/max modes, parametrised widths, and async reset.

Parameters:
NCHAN, 4, number of channels
DW, 32, sample/result width (signed two's complement)
ACCW, 64, per-channel accumulator width (signed, ACCW > DW)
CNTW, 32, sample-counter width (unsigned)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
mode_i  in  2  0=difference, 1=average, 2=minimum, 3=maximum
enable_i  in  1  window run; rising edge starts, low aborts
trig_i  in  1  end-of-window strobe
inp_i  in  NCHAN*DW  channel c at bits [c*DW +: DW]
out_o  out  NCHAN*DW  results, same packing
ready_o  out  1  one-cycle pulse, out_o valid
err_o  out  2  [0] accumulator/counter overflow, [1] trigger while busy; both sticky

Behaviour:
- Reset: one clock; asynchronous, active-high reset_i; out_o=0, ready_o=0, err_o=0, FSM=IDLE, all accumulators/counters/refs=0. Reset mid-operation discards all work; no ready_o after release.
- mode_i is latched only on the enable_i rising edge. Later changes are ignored until the next rising edge.
- FSM states: IDLE, RUN, DIV.
- IDLE -> RUN on enable_i 0->1.
- Rising-edge cycle actions:
  - err_o cleared.
  - Per channel: ref=inp, acc=inp (sign-extended), cnt=1, min=max=inp.
- RUN, every cycle with no trig_i: acc+=inp, cnt+=1, min=min(min,inp), max=max(max,inp).
- Trig cycle: inp_i of the trig cycle is included in the closing window. The new window starts with the next cycle's sample (acc=0, cnt=0, min=+max, max=-max reinitialise on first sample).
- Difference mode: out=inp-ref, wrapped to DW bits. ref<=inp. ready_o on the 1st clk edge after the trig-sampling edge. Stays RUN.
- Min/max modes: out=window min/max; ready_o latency 1. Stays RUN.
- Average mode, on trig: snapshot acc/cnt per channel, then -> DIV.
  - Each channel has its own parallel signed restoring divider: quotient truncated toward zero, ACCW iterations plus sign fixup.
  - ready_o rises ACCW+2 edges after the trig-sampling edge; out_o updated in the same cycle. Then -> RUN.
  - Accumulation of the new window continues during DIV.
- trig_i while in DIV: err_o[1]<=1. That trig is ignored; the window is not closed and no extra ready_o is produced.
- Overflow: signed overflow of any channel acc, or cnt reaching 2^CNTW-1, sets err_o[0]. The current window produces no ready_o; the next window proceeds normally.
- enable_i low: -> IDLE immediately, including from DIV. Pending results are dropped, trig_i ignored, out_o holds its last value, err_o holds.
- trig_i on the enable rising-edge cycle is ignored.
- ready_o is never asserted in IDLE or in the cycle after reset.
- out_o changes only in the cycle ready_o is high.

Test Plan:
- Difference, NCHAN=4: enable rise with ch0=100, ch1=-5; trig with ch0=350, ch1=-5 -> 1 cycle later ready_o=1, ch0=250, ch1=0. Next trig with ch0=300 -> ch0=-50.
- Average: ch0 samples 10,20,30,41 (trig on 41), ch1 samples -10,-20,-30,-41 -> ready_o exactly 66 edges after trig edge, ch0=25, ch1=-25.
- Busy trig: in average mode, second trig 10 cycles after first -> err_o=2'b10, only one ready_o pulse, window continues. Next trig after ready -> normal result including the extra samples.
- Overflow: ACCW=34, ch0=0x7FFFFFFF for 5 cycles then trig -> err_o=2'b01, no ready_o. Re-enable -> err_o=0.
- Min/max: mode 3, ch0 samples 5,-7,12,3 (trig on 3) -> out ch0=12. Mode 2 on the same data -> -7. Mode change mid-run has no effect until re-enable.
- Abort/reset: enable low 20 cycles into DIV -> no ready_o, out_o unchanged. reset_i mid-DIV -> out_o=0, err_o=0 immediately, no ready_o afterwards.

Source files
------------

// File: rtl/filter_multi.sv
// Multi-channel window filter: per-channel difference, average, min or max
// over trigger-delimited windows, with one shared enable/trig/mode.
module filter_multi #(
    parameter int NCHAN = 4,
    parameter int DW    = 32,
    parameter int ACCW  = 64,
    parameter int CNTW  = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [1:0]          mode_i,
    input  logic                enable_i,
    input  logic                trig_i,
    input  logic [NCHAN*DW-1:0] inp_i,
    output logic [NCHAN*DW-1:0] out_o,
    output logic                ready_o,
    output logic [1:0]          err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DIV} state_t;

    localparam int SW = $clog2(ACCW + 2);
    localparam logic [1:0] M_DIFF = 2'd0;
    localparam logic [1:0] M_AVG  = 2'd1;
    localparam logic [1:0] M_MIN  = 2'd2;
    localparam logic [1:0] M_MAX  = 2'd3;
    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] NMAX = {1'b1, {(DW-2){1'b0}}, 1'b1};

    state_t state, state_n;
    logic en_q, rise, active, close, busy, fresh, ovf_now, bad, pend;
    logic [1:0] mode_q;
    logic [CNTW-1:0] cnt, cnt_n, dden;
    logic win_ovf;
    logic [SW-1:0] step;
    logic [NCHAN*DW-1:0] res;
    logic [NCHAN-1:0] aovf, dneg;

    logic signed [DW-1:0]   smp [NCHAN];
    logic signed [DW-1:0]   refv [NCHAN];
    logic signed [DW-1:0]   mn [NCHAN];
    logic signed [DW-1:0]   mx [NCHAN];
    logic signed [DW-1:0]   mn_n [NCHAN];
    logic signed [DW-1:0]   mx_n [NCHAN];
    logic signed [ACCW-1:0] acc [NCHAN];
    logic signed [ACCW-1:0] sx [NCHAN];
    logic signed [ACCW-1:0] acc_n [NCHAN];
    logic [ACCW-1:0]        mag [NCHAN];
    logic [ACCW-1:0]        dq [NCHAN];
    logic [CNTW:0]          drem [NCHAN];
    logic [CNTW+1:0]        trial [NCHAN];
    logic [CNTW+1:0]        dif [NCHAN];

    assign rise    = enable_i & ~en_q;
    assign active  = enable_i && (state != IDLE);
    assign close   = active && trig_i && (state == RUN);
    assign busy    = active && trig_i && (state == DIV);
    assign fresh   = (cnt == '0);
    assign cnt_n   = cnt + CNTW'(1);
    assign ovf_now = (|aovf) || (cnt_n == '1);
    assign bad     = win_ovf || ovf_now;

    // Window update and one restoring-divider step, per channel.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            smp[c]   = inp_i[c*DW +: DW];
            sx[c]    = {{(ACCW-DW){smp[c][DW-1]}}, smp[c]};
            acc_n[c] = fresh ? sx[c] : acc[c] + sx[c];
            aovf[c]  = !fresh && (acc[c][ACCW-1] == sx[c][ACCW-1])
                       && (acc_n[c][ACCW-1] != acc[c][ACCW-1]);
            mn_n[c]  = (fresh || smp[c] < mn[c]) ? smp[c] : mn[c];
            mx_n[c]  = (fresh || smp[c] > mx[c]) ? smp[c] : mx[c];
            mag[c]   = acc_n[c][ACCW-1] ? -acc_n[c] : acc_n[c];
            trial[c] = {drem[c], dq[c][ACCW-1]};
            dif[c]   = trial[c] - {2'b00, dden};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (rise) state_n = RUN;
            RUN:     if (close && !bad && mode_q == M_AVG) state_n = DIV;
            DIV:     if (step == SW'(ACCW)) state_n = RUN;
            default: state_n = IDLE;
        endcase
        if (!enable_i) state_n = IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q    <= 1'b0;
            mode_q  <= '0;
            cnt     <= '0;
            win_ovf <= 1'b0;
            pend    <= 1'b0;
            res     <= '0;
            out_o   <= '0;
            ready_o <= 1'b0;
            err_o   <= '0;
            dden    <= '0;
            step    <= '0;
            dneg    <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                acc[c]  <= '0;
                refv[c] <= '0;
                mn[c]   <= '0;
                mx[c]   <= '0;
                dq[c]   <= '0;
                drem[c] <= '0;
            end
        end else begin
            en_q    <= enable_i;
            ready_o <= 1'b0;
            if (!enable_i) begin
                pend <= 1'b0;
            end else if (pend) begin
                out_o   <= res;
                ready_o <= 1'b1;
                pend    <= 1'b0;
            end
            if (rise) begin
                err_o   <= '0;
                mode_q  <= mode_i;
                cnt     <= CNTW'(1);
                win_ovf <= 1'b0;
                for (int c = 0; c < NCHAN; c++) begin
                    refv[c] <= smp[c];
                    acc[c]  <= sx[c];
                    mn[c]   <= smp[c];
                    mx[c]   <= smp[c];
                end
            end else if (active) begin
                err_o <= err_o | {busy, ovf_now};
                if (close) begin
                    cnt     <= '0;
                    win_ovf <= 1'b0;
                    for (int c = 0; c < NCHAN; c++) begin
                        acc[c]  <= '0;
                        mn[c]   <= SMAX;
                        mx[c]   <= NMAX;
                        refv[c] <= smp[c];
                        if (!bad) begin
                            unique case (mode_q)
                                M_DIFF: res[c*DW +: DW] <= smp[c] - refv[c];
                                M_MIN:  res[c*DW +: DW] <= mn_n[c];
                                M_MAX:  res[c*DW +: DW] <= mx_n[c];
                                M_AVG: begin
                                    dq[c]   <= mag[c];
                                    drem[c] <= '0;
                                    dneg[c] <= acc_n[c][ACCW-1];
                                end
                            endcase
                        end
                    end
                    if (!bad) begin
                        dden <= cnt_n;
                        step <= '0;
                        if (mode_q != M_AVG) pend <= 1'b1;
                    end
                end else begin
                    cnt     <= cnt_n;
                    win_ovf <= win_ovf | ovf_now;
                    for (int c = 0; c < NCHAN; c++) begin
                        acc[c] <= acc_n[c];
                        mn[c]  <= mn_n[c];
                        mx[c]  <= mx_n[c];
                    end
                end
                // Divider keeps stepping while the next window accumulates.
                if (state == DIV) begin
                    step <= step + SW'(1);
                    for (int c = 0; c < NCHAN; c++) begin
                        if (step != SW'(ACCW)) begin
                            dq[c]   <= {dq[c][ACCW-2:0], ~dif[c][CNTW+1]};
                            drem[c] <= dif[c][CNTW+1] ? trial[c][CNTW:0]
                                                      : dif[c][CNTW:0];
                        end else begin
                            res[c*DW +: DW] <= dneg[c] ? -dq[c][DW-1:0]
                                                       : dq[c][DW-1:0];
                        end
                    end
                    if (step == SW'(ACCW)) pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_multi.sv
// Directed bench for filter_multi: cycle tables for difference/min/max,
// hand sequences for average latency, busy trig, abort, reset and overflow.
module tb_filter_multi;

    typedef struct {
        logic         en;
        logic         tr;
        logic [1:0]   md;
        logic [127:0] inp;
        logic         rdy;
        logic [127:0] out;
        logic [1:0]   err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en, tr, en_b, tr_b;
    logic [1:0] md, md_b;
    logic [127:0] inp, inp_b;
    logic [127:0] out, out_b;
    logic rdy, rdy_b;
    logic [1:0] err, err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    filter_multi #(.NCHAN(4), .DW(32), .ACCW(64), .CNTW(32)) u_a (
        .clk_i(clk), .reset_i(rst), .mode_i(md), .enable_i(en),
        .trig_i(tr), .inp_i(inp), .out_o(out), .ready_o(rdy), .err_o(err)
    );

    filter_multi #(.NCHAN(4), .DW(32), .ACCW(34), .CNTW(32)) u_b (
        .clk_i(clk), .reset_i(rst), .mode_i(md_b), .enable_i(en_b),
        .trig_i(tr_b), .inp_i(inp_b), .out_o(out_b), .ready_o(rdy_b),
        .err_o(err_b)
    );

    function automatic logic [127:0] pk(input int a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t v(input logic e, t, input logic [1:0] m,
                               input logic [127:0] i, input logic r,
                               input logic [127:0] o, input logic [1:0] er);
        vec_t x;
        x.en = e; x.tr = t; x.md = m; x.inp = i;
        x.rdy = r; x.out = o; x.err = er;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tv[$];
        int imin;
        int p;
        int first, second, n;
        logic [127:0] z, o1, o2, o3, o4, o5, o6;
        imin = -2147483647 - 1;
        p = 2147483647;
        z = '0;
        o1 = pk(250, 0, -4, 0);
        o2 = pk(-50, 0, 0, -9);
        o3 = pk(12, -3, 0, 2);
        o4 = pk(100, 100, 100, 100);
        o5 = pk(-7, -9, 0, imin);
        o6 = pk(5, 0, -30, -80);
        // difference, with a mode change that must be ignored
        tv.push_back(v(1, 0, 0, pk(100, -5, 7, 0), 0, z, 0));
        tv.push_back(v(1, 1, 0, pk(350, -5, 3, 0), 0, z, 0));
        tv.push_back(v(1, 0, 0, pk(1, 1, 1, 1), 1, o1, 0));
        tv.push_back(v(1, 1, 0, pk(300, -5, 3, -9), 0, o1, 0));
        tv.push_back(v(1, 0, 3, z, 1, o2, 0));
        tv.push_back(v(0, 0, 0, z, 0, o2, 0));
        tv.push_back(v(0, 1, 0, z, 0, o2, 0));
        // maximum, then a second back-to-back window
        tv.push_back(v(1, 0, 3, pk(5, -3, 0, imin), 0, o2, 0));
        tv.push_back(v(1, 0, 2, pk(-7, -9, 0, 1), 0, o2, 0));
        tv.push_back(v(1, 0, 2, pk(12, -4, 0, 2), 0, o2, 0));
        tv.push_back(v(1, 1, 2, pk(3, -8, 0, imin), 0, o2, 0));
        tv.push_back(v(1, 0, 2, o4, 1, o3, 0));
        tv.push_back(v(1, 1, 0, pk(-1, -200, 50, 0), 0, o3, 0));
        tv.push_back(v(1, 0, 0, z, 1, o4, 0));
        tv.push_back(v(0, 0, 0, z, 0, o4, 0));
        // minimum on the same data
        tv.push_back(v(1, 0, 2, pk(5, -3, 0, imin), 0, o4, 0));
        tv.push_back(v(1, 0, 3, pk(-7, -9, 0, 1), 0, o4, 0));
        tv.push_back(v(1, 0, 3, pk(12, -4, 0, 2), 0, o4, 0));
        tv.push_back(v(1, 1, 3, pk(3, -8, 0, imin), 0, o4, 0));
        tv.push_back(v(1, 0, 3, z, 1, o5, 0));
        tv.push_back(v(0, 0, 0, z, 0, o5, 0));
        // trig on the enable rising edge is ignored
        tv.push_back(v(1, 1, 0, pk(10, 20, 30, 40), 0, o5, 0));
        tv.push_back(v(1, 0, 0, z, 0, o5, 0));
        tv.push_back(v(1, 1, 0, pk(15, 20, 0, -40), 0, o5, 0));
        tv.push_back(v(1, 0, 0, z, 1, o6, 0));
        tv.push_back(v(0, 0, 0, z, 0, o6, 0));

        rst = 1'b1;
        en = 0; tr = 0; md = 0; inp = '0;
        en_b = 0; tr_b = 0; md_b = 0; inp_b = '0;
        tick();
        chk("rst_out", out, z);
        chk("rst_rdy", 128'(rdy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_out_b", out_b, z);
        rst = 1'b0;

        foreach (tv[i]) begin
            en = tv[i].en; tr = tv[i].tr; md = tv[i].md; inp = tv[i].inp;
            tick();
            chk($sformatf("v%0d_rdy", i), 128'(rdy), 128'(tv[i].rdy));
            chk($sformatf("v%0d_out", i), out, tv[i].out);
            chk($sformatf("v%0d_err", i), 128'(err), 128'(tv[i].err));
        end

        // average: latency ACCW+2 edges, truncation toward zero
        en = 1; md = 1; tr = 0;
        inp = pk(10, -10, 7, -7); tick();
        inp = pk(20, -20, 7, -7); tick();
        inp = pk(30, -30, 7, -7); tick();
        tr = 1; inp = pk(41, -41, -8, 8); tick();
        tr = 0; inp = '0;
        first = 0; n = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 65) chk("avg_hold", out, o6);
            if (rdy) begin
                n++;
                if (first == 0) begin
                    first = k;
                    chk("avg_out", out, pk(25, -25, 3, -3));
                end
            end
        end
        chki("avg_lat", first, 66);
        chki("avg_pulses", n, 1);

        // busy trig during DIV: error, no extra pulse, window continues
        en = 0; tick();
        en = 1; inp = pk(2, -2, 6, 0); tick();
        tr = 1; inp = pk(4, -4, 6, 0); tick();
        first = 0; second = 0; n = 0;
        for (int k = 1; k <= 150; k++) begin
            tr = (k == 10 || k == 70);
            inp = (k <= 70) ? pk(k, -k, 3, (k <= 10) ? -1 : 100) : '0;
            tick();
            if (k == 9) chk("busy_pre", 128'(err), 128'(0));
            if (k == 10) chk("busy_err", 128'(err), 128'(2));
            if (rdy) begin
                n++;
                if (n == 1) begin
                    first = k;
                    chk("busy_out1", out, pk(3, -3, 6, 0));
                end else if (n == 2) begin
                    second = k;
                    chk("busy_out2", out, pk(35, -35, 3, 85));
                end
            end
        end
        tr = 0;
        chki("busy_lat1", first, 66);
        chki("busy_lat2", second, 136);
        chki("busy_pulses", n, 2);
        chk("busy_sticky", 128'(err), 128'(2));

        // enable low 20 cycles into DIV drops the result
        en = 0; tick();
        en = 1; inp = pk(8, 8, 8, 8); tick();
        chk("rise_clr", 128'(err), 128'(0));
        tr = 1; tick();
        tr = 0; inp = '0; n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rdy) n++;
        end
        en = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (rdy) n++;
        end
        chki("abort_pulses", n, 0);
        chk("abort_out", out, pk(35, -35, 3, 85));

        // reset mid-DIV clears immediately, no pulse afterwards
        en = 1; inp = pk(8, 8, 8, 8); tick();
        tr = 1; tick();
        for (int k = 1; k <= 30; k++) begin
            tr = (k == 10);
            tick();
        end
        tr = 0;
        chk("rst_pre_err", 128'(err), 128'(2));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out", out, z);
        chk("rst_mid_err", 128'(err), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (rdy) n++;
        end
        chki("rst_pulses", n, 0);
        en = 0;

        // overflow with ACCW=34: window dropped, next window normal
        en_b = 1; md_b = 1; tr_b = 0; inp_b = pk(p, 1, 0, 0);
        for (int k = 1; k <= 4; k++) tick();
        chk("ovf_below", 128'(err_b), 128'(0));
        tick();
        chk("ovf_set", 128'(err_b), 128'(1));
        tr_b = 1; inp_b = pk(0, 1, 0, 0); tick();
        tr_b = 0; inp_b = pk(6, -6, 0, 0); tick();
        tr_b = 1; inp_b = pk(9, -9, 0, 0); tick();
        tr_b = 0; inp_b = '0;
        first = 0; n = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (rdy_b) begin
                n++;
                if (first == 0) begin
                    first = k;
                    chk("ovf_next_out", out_b, pk(7, -7, 0, 0));
                end
            end
        end
        chki("ovf_next_lat", first, 36);
        chki("ovf_pulses", n, 1);
        chk("ovf_sticky", 128'(err_b), 128'(1));
        en_b = 0; tick();
        en_b = 1; tick();
        chk("ovf_clr", 128'(err_b), 128'(0));
        en_b = 0; tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
